// File: rtl/stream_dword_serializer.sv
// Buffers 32-bit words with a byte count and emits them one byte per cycle on a
// valid/ready byte stream, in LSB-first or MSB-first order.
module stream_dword_serializer #(
    parameter int unsigned DEPTH     = 2,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_s_valid,
    output logic        o_s_ready,
    input  logic [31:0] i_s_data,
    input  logic [1:0]  i_s_nbytes,
    output logic        o_m_valid,
    input  logic        i_m_ready,
    output logic [7:0]  o_m_data,
    output logic        o_m_last,
    output logic        o_busy,
    output logic [15:0] o_byte_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [PtrW-1:0] PtrMax  = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    state_e          r_state, w_state_d;
    logic [31:0]     r_mem_data   [DEPTH];
    logic [1:0]      r_mem_nbytes [DEPTH];
    logic [PtrW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CntW-1:0] r_count, w_count_d;
    logic [1:0]      r_k, w_k_d;
    logic [15:0]     r_byte_count;

    logic            w_emit, w_push, w_pop, w_fire, w_last;
    logic [31:0]     w_head;
    logic [1:0]      w_sel;
    logic [7:0]      w_byte;

    // Outputs are forced quiet while reset is held, not just after the reset edge.
    assign w_emit    = (r_state == StEmit) && !i_reset;
    assign o_s_ready = !i_reset && (r_count != CntFull);
    assign w_push    = i_s_valid && o_s_ready;
    assign w_head    = r_mem_data[r_rd_ptr];
    assign w_last    = (r_k == r_mem_nbytes[r_rd_ptr]);
    assign w_fire    = w_emit && i_m_ready;
    assign w_pop     = w_fire && w_last;

    // MSB-first byte k is physical byte 3-k, i.e. the bitwise inverse of k.
    assign w_sel = LSB_FIRST ? r_k : ~r_k;

    always_comb begin
        w_byte = 8'h00;
        unique case (w_sel)
            2'd0: w_byte = w_head[7:0];
            2'd1: w_byte = w_head[15:8];
            2'd2: w_byte = w_head[23:16];
            2'd3: w_byte = w_head[31:24];
            default: w_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_count_d = r_count;
        if (w_push && !w_pop) begin
            w_count_d = r_count + CntW'(1);
        end else if (!w_push && w_pop) begin
            w_count_d = r_count - CntW'(1);
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_k_d     = r_k;
        unique case (r_state)
            StIdle: begin
                if (r_count != '0) begin
                    w_state_d = StEmit;
                    w_k_d     = 2'd0;
                end
            end
            StEmit: begin
                if (i_m_ready) begin
                    if (!w_last) begin
                        w_k_d = r_k + 2'd1;
                    end else begin
                        w_k_d = 2'd0;
                        if (w_count_d == '0) begin
                            w_state_d = StIdle;
                        end
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
                w_k_d     = 2'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_k          <= 2'd0;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_byte_count <= 16'h0000;
        end else begin
            r_state <= w_state_d;
            r_k     <= w_k_d;
            r_count <= w_count_d;
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PtrMax) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PtrMax) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_fire) begin
                r_byte_count <= r_byte_count + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr]   <= i_s_data;
            r_mem_nbytes[r_wr_ptr] <= i_s_nbytes;
        end
    end

    assign o_m_valid    = w_emit;
    assign o_m_data     = w_emit ? w_byte : 8'h00;
    assign o_m_last     = w_emit && w_last;
    assign o_busy       = !i_reset && ((r_count != '0) || (r_state == StEmit));
    assign o_byte_count = r_byte_count;

endmodule

// File: tb/tb_stream_dword_serializer.sv
// Drives an LSB-first and an MSB-first serializer with identical stimulus and
// checks every emitted byte against a queue of expected bytes.
module tb_stream_dword_serializer;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  nb;
        logic [7:0]  last_lsb;
        logic [7:0]  last_msb;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic [31:0] s_data;
    logic [1:0]  s_nbytes;
    logic        m_ready;

    logic        s_ready_a, m_valid_a, m_last_a, busy_a;
    logic [7:0]  m_data_a;
    logic [15:0] byte_count_a;
    logic        s_ready_b, m_valid_b, m_last_b, busy_b;
    logic [7:0]  m_data_b;
    logic [15:0] byte_count_b;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_bc;
    logic [8:0]  q_a[$];
    logic [8:0]  q_b[$];
    logic        prev_stall;
    logic [8:0]  prev_out;

    always #5 clk = ~clk;

    stream_dword_serializer #(.DEPTH(2), .LSB_FIRST(1'b1)) dut_a (
        .i_clk(clk), .i_reset(reset), .i_s_valid(s_valid), .o_s_ready(s_ready_a),
        .i_s_data(s_data), .i_s_nbytes(s_nbytes), .o_m_valid(m_valid_a),
        .i_m_ready(m_ready), .o_m_data(m_data_a), .o_m_last(m_last_a),
        .o_busy(busy_a), .o_byte_count(byte_count_a)
    );

    stream_dword_serializer #(.DEPTH(2), .LSB_FIRST(1'b0)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_s_valid(s_valid), .o_s_ready(s_ready_b),
        .i_s_data(s_data), .i_s_nbytes(s_nbytes), .o_m_valid(m_valid_b),
        .i_m_ready(m_ready), .o_m_data(m_data_b), .o_m_last(m_last_b),
        .o_busy(busy_b), .o_byte_count(byte_count_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Scoreboard: pop on each byte handshake, push expected bytes on each word accept.
    always @(negedge clk) begin
        if (reset) begin
            q_a.delete();
            q_b.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold", {m_valid_a, m_last_a, m_data_a}, {1'b1, prev_out});
            end
            if (m_valid_a && m_ready) begin
                if (q_a.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_byte_a: got %h, want none", m_data_a);
                end else begin
                    check("byte_lsb", {m_last_a, m_data_a}, q_a.pop_front());
                end
            end
            if (m_valid_b && m_ready) begin
                if (q_b.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_byte_b: got %h, want none", m_data_b);
                end else begin
                    check("byte_msb", {m_last_b, m_data_b}, q_b.pop_front());
                end
            end
            if (s_valid && s_ready_a) begin
                for (int k = 0; k <= int'(s_nbytes); k++) begin
                    q_a.push_back({k == int'(s_nbytes), s_data[8*k +: 8]});
                    q_b.push_back({k == int'(s_nbytes), s_data[8*(3-k) +: 8]});
                end
            end
            prev_stall = m_valid_a && !m_ready;
            prev_out   = {m_last_a, m_data_a};
        end
    end

    // Returns 1 time unit after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic [1:0] nb);
        bit acc = 1'b0;
        s_valid  = 1'b1;
        s_data   = d;
        s_nbytes = nb;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = s_ready_a;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!acc) check("send_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic run_word(input vec_t v);
        int         cyc = 0;
        bit         done = 1'b0;
        logic [7:0] la = 8'h00;
        logic [7:0] lb = 8'h00;
        m_ready = 1'b1;
        exp_bc  = exp_bc + 16'(v.nb) + 16'd1;
        send_word(v.data, v.nb);
        @(negedge clk);
        check("first_latency", {31'd0, m_valid_a}, 32'd0);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            cyc++;
            if (m_valid_a && m_last_a) begin
                done = 1'b1;
                la   = m_data_a;
                lb   = m_data_b;
            end
        end
        check("emit_done", {31'd0, done}, 32'd1);
        check("burst_len", cyc, 32'(v.nb) + 32'd1);
        check("last_lsb", {24'd0, la}, {24'd0, v.last_lsb});
        check("last_msb", {24'd0, lb}, {24'd0, v.last_msb});
        @(negedge clk);
        check("busy_after", {31'd0, busy_a}, 32'd0);
        check("bc_lsb", {16'd0, byte_count_a}, {16'd0, exp_bc});
        check("bc_msb", {16'd0, byte_count_b}, {16'd0, exp_bc});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_bc = 16'h0000;
    endtask

    initial begin
        vec_t       vecs[5];
        bit [5:0]   ptn;
        int         fires, n, ready_at;
        bit         idle;

        vecs[0] = '{32'hDDCCBBAA, 2'd3, 8'hDD, 8'hAA};
        vecs[1] = '{32'h11223344, 2'd1, 8'h33, 8'h22};
        vecs[2] = '{32'h000000EE, 2'd0, 8'hEE, 8'h00};
        vecs[3] = '{32'h04030201, 2'd2, 8'h03, 8'h02};
        vecs[4] = '{32'hCAFEF00D, 2'd3, 8'hCA, 8'h0D};

        reset = 1'b1; s_valid = 1'b0; s_data = '0; s_nbytes = '0; m_ready = 1'b0;
        exp_bc = 16'h0000; prev_stall = 1'b0; prev_out = '0;

        // Reset state
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_m_valid", {31'd0, m_valid_a}, 32'd0);
        check("rst_m_last", {31'd0, m_last_a}, 32'd0);
        check("rst_m_data", {24'd0, m_data_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_s_ready", {31'd0, s_ready_a}, 32'd0);
        check("rst_byte_count", {16'd0, byte_count_a}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", {31'd0, s_ready_a}, 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) run_word(vecs[i]);

        // Fill a DEPTH=2 buffer while stalled, third word held off until the first pop.
        m_ready = 1'b0;
        send_word(32'hA3A2A1A0, 2'd3);
        send_word(32'hB3B2B1B0, 2'd3);
        s_valid = 1'b1; s_data = 32'hC3C2C1C0; s_nbytes = 2'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_s_ready", {31'd0, s_ready_a}, 32'd0);
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        fires = 0; n = 0; ready_at = -1;
        for (int i = 0; i < 40 && fires < 12; i++) begin
            @(negedge clk);
            n++;
            if (m_valid_a) fires++;
            if (s_valid && s_ready_a && ready_at < 0) ready_at = i;
            @(posedge clk);
            #1;
            if (ready_at >= 0) s_valid = 1'b0;
        end
        exp_bc = exp_bc + 16'd12;
        check("burst12_bytes", fires, 32'd12);
        check("burst12_cycles", n, 32'd12);
        check("ready_return", ready_at, 32'd4);
        @(negedge clk);
        check("burst12_busy", {31'd0, busy_a}, 32'd0);
        check("burst12_bc", {16'd0, byte_count_a}, {16'd0, exp_bc});
        @(posedge clk);
        #1;

        // Backpressure pattern 1,0,0,1 then continuous.
        ptn = 6'b111001;
        m_ready = 1'b1;
        send_word(32'h04030201, 2'd3);
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            m_ready = ptn[i];
            @(negedge clk);
            if (!ptn[i]) check("stall_data", {24'd0, m_data_a}, 32'h02);
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        exp_bc = exp_bc + 16'd4;
        @(negedge clk);
        check("stall_busy", {31'd0, busy_a}, 32'd0);
        check("stall_bc", {16'd0, byte_count_a}, {16'd0, exp_bc});
        @(posedge clk);
        #1;

        // Reset one cycle after the second byte handshakes.
        send_word(32'hA4A3A2A1, 2'd3);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_bc = 16'h0000;
        @(negedge clk);
        check("mid_rst_m_valid", {31'd0, m_valid_a}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        check("mid_rst_bc", {16'd0, byte_count_a}, 32'd0);
        check("mid_rst_s_ready", {31'd0, s_ready_a}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
        end
        run_word(vecs[2]);

        // byte_count wrap after 65537 single-byte words.
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 65537; i++) send_word($urandom, 2'd0);
        idle = 1'b0;
        for (int i = 0; i < 20 && !idle; i++) begin
            @(negedge clk);
            idle = !busy_a;
        end
        check("wrap_idle", {31'd0, idle}, 32'd1);
        check("wrap_bc_lsb", {16'd0, byte_count_a}, 32'h0001);
        check("wrap_bc_msb", {16'd0, byte_count_b}, 32'h0001);
        check("wrap_queue", q_a.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_dword_serializer.md
STREAM_DWORD_SERIALIZER -- requirements
Module: stream_dword_serializer

Interface
REQ-001 Parameter DEPTH, default 2: number of 32-bit words the input buffer holds (legal 2..8, power of two).
REQ-002 Parameter LSB_FIRST, default 1: 1 = byte [7:0] leaves first; 0 = byte [31:24] leaves first.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 s_valid  input  1  upstream word valid.
REQ-006 s_ready  output  1  block can accept a word this cycle.
REQ-007 s_data  input  32  upstream word.
REQ-008 s_nbytes  input  2  valid bytes in word minus 1 (0 = 1 byte, 3 = 4 bytes); bytes counted in emission order.
REQ-009 m_valid  output  1  byte output valid; drives downstream stream_in_valid.
REQ-010 m_ready  input  1  downstream ready; driven from downstream stream_in_ready.
REQ-011 m_data  output  8  byte output; drives downstream stream_in_data.
REQ-012 m_last  output  1  high with m_valid on the final byte of a word.
REQ-013 busy  output  1  high when buffer non-empty or a word is mid-emission.
REQ-014 byte_count  output  16  total bytes handed off since reset, wraps modulo 2^16.

Function
REQ-015 Input handshake: word accepted on a cycle with s_valid=1 and s_ready=1.
REQ-016 s_ready = 1 when buffer occupancy < DEPTH; s_ready has no combinational path from m_ready or s_valid.
REQ-017 Buffer: FIFO of DEPTH entries of {s_nbytes, s_data}; write pointer and read pointer wrap from DEPTH-1 to 0; occupancy 0..DEPTH.
REQ-018 Simultaneous push and pop at occupancy DEPTH cannot occur (s_ready=0); at any other occupancy both take effect, occupancy unchanged.
REQ-019 Output state machine: states IDLE and EMIT.
REQ-020 IDLE -> EMIT when occupancy > 0; byte index k cleared to 0.
REQ-021 EMIT: m_valid=1; m_data = byte k of head word (byte k = s_data[8k+7:8k] if LSB_FIRST=1, s_data[31-8k:24-8k] otherwise); m_last = (k == head s_nbytes).
REQ-022 EMIT, m_ready=1, m_last=0: k increments by 1.
REQ-023 EMIT, m_ready=1, m_last=1: head word popped; if occupancy after pop > 0, stay EMIT with k=0 (back-to-back, no bubble), else -> IDLE.
REQ-024 EMIT, m_ready=0: m_data, m_last, m_valid held stable; k unchanged.
REQ-025 m_valid never deasserts before its handshake completes.
REQ-026 Latency: word accepted at edge N into an empty block gives m_valid=1 with its first byte in cycle after edge N+1 (one registered stage); no combinational s_data -> m_data path.
REQ-027 Sustained throughput: one byte per cycle while m_ready=1 and buffer non-empty.
REQ-028 byte_count increments by 1 on each m_valid&&m_ready cycle; 16'hFFFF + 1 -> 16'h0000.
REQ-029 busy = (occupancy != 0) || (state == EMIT).
REQ-030 Bytes of a word beyond s_nbytes are never emitted.

Reset
REQ-031 reset high at a rising edge: state IDLE, occupancy 0, pointers 0, k 0, byte_count 0.
REQ-032 Outputs during/after reset: m_valid=0, m_last=0, m_data=8'h00, busy=0, s_ready=0 while reset=1, s_ready=1 first cycle after reset releases.
REQ-033 Reset mid-emission discards buffered and partially emitted words; no remaining byte of them appears after reset.

Verification
REQ-034 Single word 32'hDDCCBBAA, nbytes=3, LSB_FIRST=1, m_ready=1 -> m_data AA,BB,CC,DD on 4 consecutive cycles, m_last only on DD, byte_count=4, busy low after.
REQ-035 LSB_FIRST=0, word 32'h11223344, nbytes=1 -> bytes 11,22 only, m_last on 22, byte_count=2.
REQ-036 Three words pushed back-to-back with m_ready=0, DEPTH=2 -> s_ready drops after 2nd accept, 3rd held off; m_ready=1 -> 12 bytes with no gaps, s_ready returns after first pop.
REQ-037 m_ready toggled 1,0,0,1 during emission of 32'h04030201 -> m_data held 02 across stall cycles, output sequence 01,02,03,04 unchanged.
REQ-038 Reset asserted one cycle after 2nd byte of a word handshakes -> m_valid=0, busy=0, byte_count=0 next cycle; subsequent word 32'h000000EE nbytes=0 emits single EE with m_last=1.
REQ-039 65537 single-byte words -> byte_count wraps to 16'h0001.
